debug_streamer: RTL and testbench

Readout end of the on-chip debug capture path. Snapshots a set of 32-bit debug words, such as the sticky handshake flags and captured datapath values, on a trigger pulse. It then serializes them as a framed byte stream over a valid/ready interface toward the host link (UART/AXI-Stream bridge). Runs in the accelerator clock domain; one frame in flight at a time.

---
 rtl/debug_streamer.sv | 190 +++++++++++++++++++
 tb/tb_debug_streamer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/debug_streamer.sv
// debug_streamer
// Snapshots NUM_WORDS 32-bit debug words on a trigger pulse. It then streams
// them as one framed byte sequence over a valid/ready interface. The frame is:
//   HEADER, seq, word0 byte0 .. word(N-1) byte3 (little-endian), checksum
// The checksum is the XOR of every preceding byte of the frame.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   trig_i          snapshot request (single-cycle pulse)
//   dbg_words_i     packed debug words, word 0 in bits [31:0]
//   out_data_o      stream byte (registered)
//   out_vld_o       byte valid (registered)
//   out_rdy_i       downstream ready
//   busy_o          frame in progress
//   frame_cnt_o     completed frames (wraps)
//   drop_cnt_o      triggers ignored while busy (saturates at 255)
module debug_streamer #(
  parameter int          NUM_WORDS = 3,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig_i,
  input  logic [NUM_WORDS*32-1:0]  dbg_words_i,
  output logic [7:0]               out_data_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic                     busy_o,
  output logic [15:0]              frame_cnt_o,
  output logic [7:0]               drop_cnt_o
);

  localparam int             NBYTES   = NUM_WORDS * 4;
  localparam int             IW       = 6;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [7:0]               seq_q, seq_d;
  logic [7:0]               csum_q, csum_d;
  logic [NUM_WORDS*32-1:0]  snap_q, snap_d;
  logic [7:0]               data_q, data_d;
  logic                     vld_q, vld_d;
  logic                     busy_q, busy_d;
  logic [15:0]              frame_q, frame_d;
  logic [7:0]               drop_q, drop_d;
  logic                     accept;

  // Byte idx of the snapshot bank; byte order matches the wire order because
  // word 0 sits in the low bits and each word goes out low byte first.
  function automatic logic [7:0] snap_byte(input logic [NUM_WORDS*32-1:0] bank,
                                           input logic [IW-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      b = (idx == IW'(i)) ? bank[i*8 +: 8] : b;
    end
    return b;
  endfunction

  assign accept = vld_q && out_rdy_i;

  // Next-state, next-byte and counter logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    snap_d  = snap_q;
    data_d  = data_q;
    vld_d   = vld_q;
    frame_d = frame_q;
    drop_d  = drop_q;

    // Any trigger outside IDLE is dropped, including on the CSUM-accept cycle.
    if (trig_i && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_i) begin
          snap_d  = dbg_words_i;
          seq_d   = frame_q[7:0];
          csum_d  = 8'h00;
          data_d  = HEADER;
          vld_d   = 1'b1;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (accept) begin
          csum_d  = csum_q ^ data_q;
          data_d  = seq_q;
          state_d = S_SEQ;
        end else begin
          state_d = S_HDR;
        end
      end
      S_SEQ: begin
        if (accept) begin
          csum_d  = csum_q ^ data_q;
          idx_d   = {IW{1'b0}};
          data_d  = snap_byte(snap_q, {IW{1'b0}});
          state_d = S_DATA;
        end else begin
          state_d = S_SEQ;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            // Checksum byte already folds in the last data byte.
            data_d  = csum_q ^ data_q;
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + 6'd1;
            data_d  = snap_byte(snap_q, idx_q + 6'd1);
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (accept) begin
          vld_d   = 1'b0;
          data_d  = 8'h00;
          frame_d = frame_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CSUM;
        end
      end
      default: begin
        vld_d   = 1'b0;
        data_d  = 8'h00;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, snapshot, stream and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= {IW{1'b0}};
      seq_q   <= 8'h00;
      csum_q  <= 8'h00;
      snap_q  <= {(NUM_WORDS*32){1'b0}};
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      frame_q <= 16'h0000;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_vld_o   = vld_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_debug_streamer.sv
// Directed testbench for debug_streamer (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_debug_streamer;

  localparam logic [95:0] WORDS = {32'h00E81908, 32'h000000FF, 32'h0000000C};

  logic         clk;
  logic         rst_n;
  logic         trig_i;
  logic [95:0]  dbg_words_i;
  logic [7:0]   out_data_o;
  logic         out_vld_o;
  logic         out_rdy_i;
  logic         busy_o;
  logic [15:0]  frame_cnt_o;
  logic [7:0]   drop_cnt_o;

  int           checks;
  int           errors;
  logic [7:0]   base[15];
  logic [7:0]   got[15];
  int           ngot;

  debug_streamer #(.NUM_WORDS(3), .HEADER(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_i      (trig_i),
    .dbg_words_i (dbg_words_i),
    .out_data_o  (out_data_o),
    .out_vld_o   (out_vld_o),
    .out_rdy_i   (out_rdy_i),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger one frame and collect accepted bytes.
  // mode 0: ready always high; mode 1: ready toggles, plus a 5-cycle low.
  // stop_after > 0 returns after that many bytes, mid-frame.
  task automatic run_frame(input int mode, input bit scramble, input bit trig_all,
                           input int stop_after);
    int         c;
    int         target;
    logic [7:0] held;
    bit         stalled;
    target  = (stop_after > 0) ? stop_after : 15;
    ngot    = 0;
    stalled = 1'b0;
    held    = 8'h00;
    trig_i  = 1'b1;
    @(negedge clk);
    trig_i = 1'b0;
    chk("hdr_latency_vld", 32'(out_vld_o), 32'd1);
    chk("hdr_latency_data", 32'(out_data_o), 32'hA5);
    c = 0;
    while (ngot < target && c < 200) begin
      if (mode == 0) out_rdy_i = 1'b1;
      else           out_rdy_i = (c % 2 == 0) && !(c >= 8 && c <= 12);
      if (scramble) dbg_words_i = {$urandom, $urandom, $urandom};
      trig_i = trig_all && out_vld_o;
      chk("vld_mid_frame", 32'(out_vld_o), 32'd1);
      chk("busy_mid_frame", 32'(busy_o), 32'd1);
      if (stalled) chk("stall_stable", 32'(out_data_o), 32'(held));
      if (out_rdy_i && out_vld_o) begin
        got[ngot] = out_data_o;
        ngot++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_data_o;
      end
      c++;
      @(negedge clk);
    end
    trig_i = 1'b0;
    if (scramble) dbg_words_i = WORDS;
    chk("frame_len", 32'(ngot), 32'(target));
    if (stop_after == 0) begin
      if (mode == 0) chk("consecutive_cycles", 32'(c), 32'd15);
      chk("vld_after_frame", 32'(out_vld_o), 32'd0);
      chk("busy_after_frame", 32'(busy_o), 32'd0);
    end
  endtask

  // Compare collected bytes with the hand-computed frame for a given seq.
  task automatic check_frame(input string tag, input logic [7:0] seq, input bit per_byte);
    logic [7:0] e;
    bit         ok;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 1)       e = seq;
      else if (i == 14) e = base[14] ^ seq;
      else              e = base[i];
      if (per_byte) chk(tag, 32'(got[i]), 32'(e));
      else if (got[i] !== e) ok = 1'b0;
    end
    if (!per_byte) chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    base = '{8'hA5, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
             8'h00, 8'h00, 8'h08, 8'h19, 8'hE8, 8'h00, 8'hAF};
    rst_n       = 1'b0;
    trig_i      = 1'b0;
    out_rdy_i   = 1'b0;
    dbg_words_i = WORDS;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_vld", 32'(out_vld_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    run_frame(0, 1'b0, 1'b0, 0);
    check_frame("basic_byte", 8'h00, 1'b1);
    chk("basic_frame_cnt", 32'(frame_cnt_o), 32'd1);

    // Backpressure
    run_frame(1, 1'b0, 1'b0, 0);
    check_frame("bp_byte", 8'h01, 1'b1);
    chk("bp_frame_cnt", 32'(frame_cnt_o), 32'd2);

    // Snapshot isolation
    run_frame(0, 1'b1, 1'b0, 0);
    check_frame("snap_byte", 8'h02, 1'b1);
    chk("snap_frame_cnt", 32'(frame_cnt_o), 32'd3);

    // Dropped triggers: 15 per frame (including CSUM-accept cycle), 20 frames
    run_frame(0, 1'b0, 1'b1, 0);
    check_frame("drop_frame0", 8'h03, 1'b0);
    chk("drop_cnt_one_frame", 32'(drop_cnt_o), 32'd15);
    for (int f = 1; f < 20; f++) begin
      run_frame(0, 1'b0, 1'b1, 0);
      check_frame("drop_frame", 8'(3 + f), 1'b0);
    end
    chk("drop_cnt_sat", 32'(drop_cnt_o), 32'd255);
    chk("drop_frame_cnt", 32'(frame_cnt_o), 32'd23);
    repeat (5) @(negedge clk);
    chk("no_extra_vld", 32'(out_vld_o), 32'd0);
    chk("no_extra_frame_cnt", 32'(frame_cnt_o), 32'd23);
    chk("drop_cnt_hold", 32'(drop_cnt_o), 32'd255);

    // Reset mid-frame: DATA byte 5 on the wire
    run_frame(0, 1'b0, 1'b0, 7);
    chk("pre_rst_vld", 32'(out_vld_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(out_vld_o), 32'd0);
    chk("midrst_data", 32'(out_data_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_vld", 32'(out_vld_o), 32'd0);
    run_frame(0, 1'b0, 1'b0, 0);
    check_frame("post_rst_byte", 8'h00, 1'b1);
    chk("post_rst_frame_cnt", 32'(frame_cnt_o), 32'd1);

    // Sequence wrap: frames 2..257 back-to-back
    for (int f = 1; f <= 256; f++) begin
      run_frame(0, 1'b0, 1'b0, 0);
      check_frame("wrap_frame", 8'(f), 1'b0);
    end
    chk("wrap_seq_byte", 32'(got[1]), 32'h00);
    chk("wrap_frame_cnt", 32'(frame_cnt_o), 32'd257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
